// File: rtl/win_line_scanner.sv
// Sequential win-line scanner for an N x N board: one start cell per cycle,
// all four directions checked in parallel, sticky result flags plus first-hit capture.
module win_line_scanner #(
   parameter int N = 3,
   parameter int K = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [2*N*N-1:0]       board,
   output logic                   busy,
   output logic                   done,
   output logic                   win_x,
   output logic                   win_o,
   output logic                   draw,
   output logic                   err,
   output logic [$clog2(N*N)-1:0] win_cell,
   output logic [1:0]             win_dir
);

   localparam int NN = N * N;
   localparam int IW = $clog2(NN);
   localparam int RW = $clog2(N);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic            w_busy;
   logic            w_done;

   logic [2*NN-1:0] r_board;
   logic [IW-1:0]   r_idx;
   logic [RW-1:0]   r_row;
   logic [RW-1:0]   r_col;
   logic            r_win_x;
   logic            r_win_o;
   logic            r_draw;
   logic            r_err;
   logic            r_not_full;
   logic [IW-1:0]   r_win_cell;
   logic [1:0]      r_win_dir;

   logic [3:0]      w_match_x;
   logic [3:0]      w_match_o;
   logic [3:0]      w_match;
   logic [1:0]      w_first_dir;
   logic [1:0]      w_code;
   logic            w_last;
   logic            w_col_last;
   logic            w_win_x_next;
   logic            w_win_o_next;
   logic            w_err_next;
   logic            w_not_full_next;

   // Cell 0 sits in the most significant pair of the board vector.
   function automatic logic [1:0] cell_code(input logic [2*NN-1:0] b, input int pos);
      logic [2*NN-1:0] s;
      s = b >> (2 * (NN - 1 - pos));
      return s[1:0];
   endfunction

   // Direction gi: 0 right, 1 down, 2 down-right, 3 down-left.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_dir
         localparam int DR   = (gi == 0) ? 0 : 1;
         localparam int DC   = (gi == 1) ? 0 : ((gi == 3) ? -1 : 1);
         localparam int STEP = DR * N + DC;

         logic w_mx;
         logic w_mo;

         always_comb begin
            int         row_end;
            int         col_end;
            int         pos;
            logic [1:0] code;
            row_end = int'(r_row) + DR * (K - 1);
            col_end = int'(r_col) + DC * (K - 1);
            w_mx    = (row_end < N) && (col_end >= 0) && (col_end < N);
            w_mo    = w_mx;
            for (int k = 0; k < K; k++) begin
               pos = int'(r_idx) + k * STEP;
               // Off-board positions are already rejected above; clamp keeps the shift legal.
               if (pos > NN - 1) pos = NN - 1;
               code = cell_code(r_board, pos);
               if (code != 2'b01) w_mx = 1'b0;
               if (code != 2'b10) w_mo = 1'b0;
            end
         end

         assign w_match_x[gi] = w_mx;
         assign w_match_o[gi] = w_mo;
      end
   endgenerate

   assign w_match    = w_match_x | w_match_o;
   assign w_code     = cell_code(r_board, int'(r_idx));
   assign w_last     = (r_idx == IW'(NN - 1));
   assign w_col_last = (r_col == RW'(N - 1));

   assign w_win_x_next    = r_win_x | (|w_match_x);
   assign w_win_o_next    = r_win_o | (|w_match_o);
   assign w_err_next      = r_err | (w_code == 2'b11);
   assign w_not_full_next = r_not_full | (w_code == 2'b00);

   always_comb begin
      w_first_dir = 2'd3;
      if (w_match[2]) w_first_dir = 2'd2;
      if (w_match[1]) w_first_dir = 2'd1;
      if (w_match[0]) w_first_dir = 2'd0;
   end

   always_comb begin
      w_state_next = r_state;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         IDLE: if (start) w_state_next = SCAN;
         SCAN: begin
            w_busy = 1'b1;
            if (w_last) w_state_next = DONE;
         end
         DONE: begin
            w_done       = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_board    <= '0;
         r_idx      <= '0;
         r_row      <= '0;
         r_col      <= '0;
         r_win_x    <= 1'b0;
         r_win_o    <= 1'b0;
         r_draw     <= 1'b0;
         r_err      <= 1'b0;
         r_not_full <= 1'b0;
         r_win_cell <= '0;
         r_win_dir  <= '0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_board    <= board;
                  r_idx      <= '0;
                  r_row      <= '0;
                  r_col      <= '0;
                  r_win_x    <= 1'b0;
                  r_win_o    <= 1'b0;
                  r_draw     <= 1'b0;
                  r_err      <= 1'b0;
                  r_not_full <= 1'b0;
                  r_win_cell <= '0;
                  r_win_dir  <= '0;
               end
            end
            SCAN: begin
               r_win_x    <= w_win_x_next;
               r_win_o    <= w_win_o_next;
               r_err      <= w_err_next;
               r_not_full <= w_not_full_next;
               // Only the first line in scan order is reported.
               if (!r_win_x && !r_win_o && (|w_match)) begin
                  r_win_cell <= r_idx;
                  r_win_dir  <= w_first_dir;
               end
               if (w_last)
                  r_draw <= !(w_win_x_next | w_win_o_next | w_err_next | w_not_full_next);
               r_idx <= r_idx + IW'(1);
               if (w_col_last) begin
                  r_col <= '0;
                  r_row <= r_row + RW'(1);
               end else begin
                  r_col <= r_col + RW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy     = w_busy;
   assign done     = w_done;
   assign win_x    = r_win_x;
   assign win_o    = r_win_o;
   assign draw     = r_draw;
   assign err      = r_err;
   assign win_cell = r_win_cell;
   assign win_dir  = r_win_dir;

endmodule

// File: tb/tb_win_line_scanner.sv
// Bench for win_line_scanner: directed table, reset corner cases and random boards
// checked against a line-search reference model, for N=3/K=3 and N=5/K=4.
module tb_win_line_scanner;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start3, start5;
   logic [17:0] board3;
   logic [49:0] board5;
   logic        busy3, done3, wx3, wo3, dr3, er3;
   logic [3:0]  cell3;
   logic [1:0]  dir3;
   logic        busy5, done5, wx5, wo5, dr5, er5;
   logic [4:0]  cell5;
   logic [1:0]  dir5;

   win_line_scanner #(.N(3), .K(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .board(board3),
      .busy(busy3), .done(done3), .win_x(wx3), .win_o(wo3), .draw(dr3),
      .err(er3), .win_cell(cell3), .win_dir(dir3)
   );

   win_line_scanner #(.N(5), .K(4)) dut5 (
      .clk(clk), .rst_n(rst_n), .start(start5), .board(board5),
      .busy(busy5), .done(done5), .win_x(wx5), .win_o(wo5), .draw(dr5),
      .err(er5), .win_cell(cell5), .win_dir(dir5)
   );

   // Result vector layout: {win_x, win_o, draw, err, cell[7:0], dir[1:0]}
   int          sel;
   logic        obs_busy, obs_done;
   logic [13:0] obs_res;

   always_comb begin
      if (sel == 1) begin
         obs_busy = busy5;
         obs_done = done5;
         obs_res  = {wx5, wo5, dr5, er5, 8'(cell5), dir5};
      end else begin
         obs_busy = busy3;
         obs_done = done3;
         obs_res  = {wx3, wo3, dr3, er3, 8'(cell3), dir3};
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [13:0] pack_res(input bit x, input bit o, input bit d, input bit e,
                                            input int c, input int dir);
      return {x, o, d, e, 8'(c), 2'(dir)};
   endfunction

   // Reference: brute-force search of every start cell and direction vector.
   function automatic logic [13:0] ref_model(input int n, input int k, input logic [49:0] bd);
      int cells[64];
      bit wx, wo, er, full, found, all;
      int fcell, fdir, r, c, dr, dc, rr, cc;
      wx = 0; wo = 0; er = 0; full = 1; found = 0; fcell = 0; fdir = 0;
      for (int i = 0; i < n * n; i++) begin
         cells[i] = int'(bd[2 * (n * n - 1 - i) +: 2]);
         if (cells[i] == 3) er = 1;
         if (cells[i] == 0) full = 0;
      end
      for (int i = 0; i < n * n; i++) begin
         r = i / n;
         c = i % n;
         for (int d = 0; d < 4; d++) begin
            dr = (d == 0) ? 0 : 1;
            dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
            for (int who = 1; who <= 2; who++) begin
               all = 1;
               for (int t = 0; t < k; t++) begin
                  rr = r + t * dr;
                  cc = c + t * dc;
                  if (rr < 0 || rr >= n || cc < 0 || cc >= n) all = 0;
                  else if (cells[rr * n + cc] != who) all = 0;
               end
               if (all) begin
                  if (who == 1) wx = 1; else wo = 1;
                  if (!found) begin
                     found = 1;
                     fcell = i;
                     fdir  = d;
                  end
               end
            end
         end
      end
      return pack_res(wx, wo, !wx && !wo && !er && full, er, fcell, fdir);
   endfunction

   function automatic logic [49:0] rand_board(input int n, input int pempty);
      logic [49:0] bd;
      int          v;
      logic [1:0]  code;
      bd = '0;
      for (int i = 0; i < n * n; i++) begin
         v = $urandom_range(0, 99);
         if (v < 2) code = 2'b11;
         else if (v < pempty) code = 2'b00;
         else code = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
         bd[2 * (n * n - 1 - i) +: 2] = code;
      end
      return bd;
   endfunction

   task automatic scan_check(input int s, input logic [49:0] bd, input bit hold,
                             input logic [13:0] exp, input string name);
      int nn, cyc, busyc, overlap, dones;
      bit seen;
      nn  = (s == 1) ? 25 : 9;
      sel = s;
      @(negedge clk);
      if (s == 1) begin board5 = bd; start5 = 1'b1; end
      else begin board3 = bd[17:0]; start3 = 1'b1; end
      @(posedge clk); #1;
      if (!hold) begin start3 = 1'b0; start5 = 1'b0; end
      board3 = 18'($urandom());
      board5 = 50'({$urandom(), $urandom()});
      check({name, ":cleared"}, 32'(obs_res), 32'(0));
      cyc = 0; busyc = 0; overlap = 0; seen = 0;
      while (!seen && cyc < 60) begin
         if (obs_busy) busyc++;
         @(posedge clk); #1;
         cyc++;
         if (obs_done) seen = 1;
         if (obs_busy && obs_done) overlap++;
      end
      start3 = 1'b0;
      start5 = 1'b0;
      check({name, ":latency"}, 32'(cyc), 32'(nn));
      check({name, ":busy_cycles"}, 32'(busyc), 32'(nn));
      check({name, ":result"}, 32'(obs_res), 32'(exp));
      dones = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (obs_done) dones++;
         if (obs_busy && obs_done) overlap++;
      end
      check({name, ":extra_done"}, 32'(dones), 32'(0));
      check({name, ":overlap"}, 32'(overlap), 32'(0));
      check({name, ":hold"}, 32'(obs_res), 32'(exp));
      $display("scan %s n=%0d board=%h result=%h expected=%h", name, nn, bd, obs_res, exp);
   endtask

   typedef struct {
      int          sel;
      logic [49:0] bd;
      bit          hold;
      logic [13:0] exp;
      string       name;
   } vec_t;

   vec_t        tbl[8];
   logic [49:0] b5_diag, b5_wrap, bd;
   int          dones;

   initial begin
      rst_n  = 1'b0;
      start3 = 1'b0;
      start5 = 1'b0;
      board3 = '0;
      board5 = '0;
      sel    = 0;

      b5_diag = '0;
      b5_wrap = '0;
      for (int i = 6; i <= 24; i += 6) b5_diag[2 * (24 - i) +: 2] = 2'b01;
      for (int i = 3; i <= 6; i++) b5_wrap[2 * (24 - i) +: 2] = 2'b01;

      tbl[0] = '{0, 50'h15000, 1'b0, pack_res(1, 0, 0, 0, 0, 0), "top_row_x"};
      tbl[1] = '{0, 50'h02220, 1'b0, pack_res(0, 1, 0, 0, 2, 3), "anti_diag_o"};
      tbl[2] = '{0, 50'h196A5, 1'b0, pack_res(0, 0, 1, 0, 0, 0), "full_draw"};
      tbl[3] = '{0, 50'h00300, 1'b0, pack_res(0, 0, 0, 1, 0, 0), "invalid_cell"};
      tbl[4] = '{0, 50'h00300, 1'b1, pack_res(0, 0, 0, 1, 0, 0), "invalid_hold_start"};
      tbl[5] = '{0, 50'h1502A, 1'b0, pack_res(1, 1, 0, 0, 0, 0), "both_win"};
      tbl[6] = '{1, b5_diag,   1'b0, pack_res(1, 0, 0, 0, 6, 2), "n5_diag_x"};
      tbl[7] = '{1, b5_wrap,   1'b0, pack_res(0, 0, 0, 0, 0, 0), "n5_row_wrap"};

      repeat (2) @(posedge clk);
      #1;
      check("reset:res3", 32'(obs_res), 32'(0));
      check("reset:busy_done3", 32'({busy3, done3}), 32'(0));
      check("reset:busy_done5", 32'({busy5, done5, wx5, wo5, dr5, er5, cell5, dir5}), 32'(0));

      // Reset wins over a simultaneous start, and the start is not remembered.
      @(negedge clk);
      board3 = 18'h15000;
      start3 = 1'b1;
      @(posedge clk); #1;
      check("rst_vs_start:busy", 32'(busy3), 32'(0));
      @(negedge clk);
      rst_n  = 1'b1;
      start3 = 1'b0;
      @(posedge clk); #1;
      check("rst_vs_start:not_queued", 32'(busy3), 32'(0));

      for (int i = 0; i < 8; i++)
         scan_check(tbl[i].sel, tbl[i].bd, tbl[i].hold, tbl[i].exp, tbl[i].name);

      // Reset in the fourth scan cycle aborts without a done pulse.
      sel = 0;
      @(negedge clk);
      board3 = 18'h15000;
      start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("mid_reset:busy_done", 32'({busy3, done3}), 32'(0));
      check("mid_reset:res", 32'(obs_res), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done3 || busy3) dones++;
      end
      check("mid_reset:no_done", 32'(dones), 32'(0));
      scan_check(0, 50'h15000, 1'b0, pack_res(1, 0, 0, 0, 0, 0), "after_reset");

      for (int i = 0; i < 120; i++) begin
         bd = rand_board(3, 25);
         scan_check(0, bd, 1'b0, ref_model(3, 3, bd), "rand_n3");
      end
      for (int i = 0; i < 30; i++) begin
         bd = rand_board(5, 8);
         scan_check(1, bd, 1'b0, ref_model(5, 4, bd), "rand_n5");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/win_line_scanner.md
WIN_LINE_SCANNER -- requirements
Module: win_line_scanner

Interface
REQ-001 Parameter N, default 3: board side length; legal range 3..8.
REQ-002 Parameter K, default 3: winning line length; legal range 3..N.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  request a scan; sampled only in IDLE.
REQ-006 board  in  2*N*N  cell i (raster order, row-major, i=0 top-left) occupies bits [2*(N*N-1-i)+1 : 2*(N*N-1-i)]; cell code 00 empty, 01 X, 10 O, 11 invalid.
REQ-007 busy  out  1  high while in SCAN.
REQ-008 done  out  1  one-cycle pulse; result outputs valid from this cycle.
REQ-009 win_x  out  1  at least one K-line of X exists.
REQ-010 win_o  out  1  at least one K-line of O exists.
REQ-011 draw  out  1  no win, no empty cell, no invalid cell.
REQ-012 err  out  1  at least one cell coded 11.
REQ-013 win_cell  out  $clog2(N*N)  start cell of first line found.
REQ-014 win_dir  out  2  direction of first line found: 0 right, 1 down, 2 down-right, 3 down-left.

Function
REQ-015 FSM states IDLE, SCAN, DONE; IDLE -> SCAN on start=1; SCAN -> DONE after index N*N-1 evaluated; DONE -> IDLE unconditionally next cycle.
REQ-016 On accepting start, board SHALL be copied into an internal register; board changes during SCAN SHALL NOT affect the result.
REQ-017 On accepting start, win_x, win_o, draw, err, win_cell, win_dir SHALL clear to 0.
REQ-018 SCAN SHALL evaluate one start cell per cycle, index 0..N*N-1, all four directions in that cycle.
REQ-019 A direction matches only if all K cells lie on the board (no wrap across rows/columns) and all K codes equal 01 (X) or all equal 10 (O).
REQ-020 Any match SHALL set win_x or win_o (sticky until next start); both may be set.
REQ-021 win_cell/win_dir SHALL capture only the first match in scan order; within one cell, priority dir 0 > 1 > 2 > 3; later matches SHALL NOT overwrite.
REQ-022 Each SCAN cycle SHALL check the current cell's code: 11 sets err (sticky), 00 marks board not full.
REQ-023 Invalid cells SHALL never contribute to a match.
REQ-024 draw SHALL be computed at SCAN exit: 1 only if win_x=0, win_o=0, err=0, and no empty cell seen.
REQ-025 Latency: start sampled at edge E; done SHALL be high exactly in the cycle after edge E+N*N, for one cycle.
REQ-026 start while in SCAN or DONE SHALL be ignored (not queued).
REQ-027 Result outputs SHALL hold after done until the next accepted start.
REQ-028 busy=1 exactly in SCAN; busy and done never high together.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force IDLE and clear busy, done, win_x, win_o, draw, err, win_cell, win_dir, scan index to 0.
REQ-030 Reset mid-SCAN SHALL abort with no done pulse; next start performs a fresh full scan.
REQ-031 rst_n has priority over start on the same edge.

Verification (N=3, K=3 unless stated)
REQ-032 board=18'h15000 (top row X), start -> done 9 cycles after start edge; win_x=1, win_o=0, win_cell=0, win_dir=0, draw=0.
REQ-033 board=18'h02220 (O at cells 2,4,6) -> win_o=1, win_cell=2, win_dir=3, win_x=0.
REQ-034 board=18'h196A5 (full, no line) -> draw=1, win_x=0, win_o=0, err=0.
REQ-035 board=18'h00300 (cell 4 invalid) -> err=1, draw=0, win_x=0, win_o=0; repeat with start held high throughout SCAN -> exactly one done pulse.
REQ-036 rst_n=0 at 4th SCAN cycle -> busy=0 next cycle, no done, all outputs 0; subsequent start with board=18'h15000 gives REQ-032 result.
REQ-037 N=5, K=4, X at cells 6,12,18,24 -> win_x=1, win_cell=6, win_dir=2, done 25 cycles after start edge; X at cells 3,4,5,6 (row wrap) -> win_x=0.
